// File: rtl/risc_pkg.sv
// Shared types for the RISC-Y sequence controller: opcodes, FSM phases, and ALU-opcode decode.
package risc_pkg;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  typedef enum logic [3:0] {
    ST_INST_ADDR  = 4'd0,
    ST_INST_FETCH = 4'd1,
    ST_INST_LOAD  = 4'd2,
    ST_IDLE       = 4'd3,
    ST_OP_ADDR    = 4'd4,
    ST_OP_FETCH   = 4'd5,
    ST_ALU_OP     = 4'd6,
    ST_STORE      = 4'd7,
    ST_HALTED     = 4'd8
  } state_t;

  // Opcodes that read an operand from memory and write the accumulator.
  function automatic logic is_aluop(opcode_t op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/risc_seq_ctrl.sv
// 8-phase Moore sequence controller for the RISC-Y core, with HLT parking.
// Optional retired-instruction counter enabled by defining SEQ_INSTR_CNT_EN.
module risc_seq_ctrl
  import risc_pkg::*;
`ifdef SEQ_INSTR_CNT_EN
  #(parameter int CNT_WIDTH = 16)
`endif
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ENABLE,
  input  logic [2:0]           OPCODE,
  input  logic                 ZERO,
  output logic                 SEL,
  output logic                 MEM_RD,
  output logic                 MEM_WR,
  output logic                 LOAD_IR,
  output logic                 LOAD_AC,
  output logic                 INC_PC,
  output logic                 LOAD_PC,
`ifdef SEQ_INSTR_CNT_EN
  output logic [CNT_WIDTH-1:0] INSTR_CNT,
`endif
  output logic                 HALT
);

  state_t  state_q, state_d, state_nxt;
  opcode_t op;
  logic    aluop;
  logic    illegal;

  assign op      = opcode_t'(OPCODE);
  assign aluop   = is_aluop(op);
  assign illegal = (state_q > ST_HALTED);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_INST_ADDR;
    else     state_q <= state_d;
  end

  // An illegal encoding recovers on the next clock even while stalled.
  always_comb begin
    state_nxt = ST_INST_ADDR;
    case (state_q)
      ST_INST_ADDR:  state_nxt = ST_INST_FETCH;
      ST_INST_FETCH: state_nxt = ST_INST_LOAD;
      ST_INST_LOAD:  state_nxt = ST_IDLE;
      ST_IDLE:       state_nxt = ST_OP_ADDR;
      ST_OP_ADDR:    state_nxt = (op == OP_HLT) ? ST_HALTED : ST_OP_FETCH;
      ST_OP_FETCH:   state_nxt = ST_ALU_OP;
      ST_ALU_OP:     state_nxt = ST_STORE;
      ST_STORE:      state_nxt = ST_INST_ADDR;
      ST_HALTED:     state_nxt = ST_HALTED;
      default:       state_nxt = ST_INST_ADDR;
    endcase
    state_d = (ENABLE || illegal) ? state_nxt : state_q;
  end

  always_comb begin
    SEL     = 1'b0;
    MEM_RD  = 1'b0;
    MEM_WR  = 1'b0;
    LOAD_IR = 1'b0;
    LOAD_AC = 1'b0;
    INC_PC  = 1'b0;
    LOAD_PC = 1'b0;
    HALT    = 1'b0;
    case (state_q)
      ST_INST_ADDR: SEL = 1'b1;
      ST_INST_FETCH: begin
        SEL    = 1'b1;
        MEM_RD = 1'b1;
      end
      ST_INST_LOAD, ST_IDLE: begin
        SEL     = 1'b1;
        MEM_RD  = 1'b1;
        LOAD_IR = 1'b1;
      end
      ST_OP_ADDR:  INC_PC = 1'b1;
      ST_OP_FETCH: MEM_RD = aluop;
      ST_ALU_OP: begin
        MEM_RD  = aluop;
        INC_PC  = (op == OP_SKZ) && ZERO;
        LOAD_PC = (op == OP_JMP);
      end
      ST_STORE: begin
        MEM_RD  = aluop;
        INC_PC  = (op == OP_JMP);
        LOAD_PC = (op == OP_JMP);
        LOAD_AC = aluop;
        MEM_WR  = (op == OP_STO);
      end
      ST_HALTED: HALT = 1'b1;
      default: ;
    endcase
  end

`ifdef SEQ_INSTR_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  // Counts retirements on the STORE -> INST_ADDR step; wraps naturally.
  always_ff @(posedge CLK) begin
    if (RST)                                  cnt_q <= '0;
    else if (ENABLE && state_q == ST_STORE)   cnt_q <= cnt_q + CNT_WIDTH'(1);
  end

  assign INSTR_CNT = cnt_q;
`endif

endmodule
